// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the memory access controller: FSM state encoding,
// the memory write-enable polarity and the default access latency.
// No ports; imported by mem_access_ctrl and lat_counter.

package mem_ctrl_pkg;

   // Controller states: wait for a request, pulse chip select, hold the bus
   // while the memory works, then hand back a one-cycle response.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // The memory's write enable is active low, so a read is the idle level.
   localparam logic WEN_WRITE = 1'b0;
   localparam logic WEN_READ  = 1'b1;

   // Access latency of the data memory, counted from the cs cycle.
   localparam int MEM_LATENCY = 3;

endpackage

// File: rtl/mem_access_ctrl_lat_counter.sv
// lat_counter
// Loadable down-counter that times the wait phase of a memory access.
// 'load' presets the count to LATENCY-1, 'dec' counts down by one, and
// 'last' flags a count of 1, i.e. the final wait cycle.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset (count cleared to 0)
//   load  - preset count to LATENCY-1
//   dec   - decrement count
//   last  - high while count == 1

module lat_counter
   import mem_ctrl_pkg::*;
#(
   parameter int LATENCY = MEM_LATENCY
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic last
);

   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] LOAD_VALUE = CW'(LATENCY - 1);
   localparam logic [CW-1:0] ONE        = CW'(1);

   logic [CW-1:0] count;

   // The counter is only ever loaded on entry to the wait phase and the
   // controller leaves that phase when the count reaches 1, so it never
   // needs to wrap; the zero guard just keeps it parked if dec is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VALUE;
      end else if (dec && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign last = (count == ONE);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// CPU-side initiator for the fixed-latency data memory. Accepts one
// load/store at a time, drives cs/wen/addr/data_in for the full access
// latency, captures read data and returns a one-cycle response.
// Ports:
//   clk, rst                 - clock and asynchronous active-low reset
//   req_valid/req_ready      - request handshake (accept when both high)
//   req_wen                  - 0 = write, 1 = read (memory polarity)
//   req_addr/req_wdata       - access address and write data
//   resp_valid/resp_rdata    - completion pulse and read data
//   busy                     - an access is in flight
//   mem_cs/mem_wen           - memory chip select / active-low write enable
//   mem_addr/mem_data_in     - memory address and write data
//   mem_data_out             - memory read data

module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ASIZE   = 16,
   parameter int DSIZE   = 16,
   parameter int LATENCY = MEM_LATENCY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_wen,
   input  logic [ASIZE-1:0] req_addr,
   input  logic [DSIZE-1:0] req_wdata,
   output logic             resp_valid,
   output logic [DSIZE-1:0] resp_rdata,
   output logic             busy,
   output logic             mem_cs,
   output logic             mem_wen,
   output logic [ASIZE-1:0] mem_addr,
   output logic [DSIZE-1:0] mem_data_in,
   input  logic [DSIZE-1:0] mem_data_out
);

   state_t state, state_next;
   logic   accept;
   logic   cnt_load;
   logic   cnt_dec;
   logic   cnt_last;
   logic   wait_done;

   // Times the wait phase; the FSM only consumes the 'last' flag.
   lat_counter #(
      .LATENCY (LATENCY)
   ) u_lat_counter (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .dec  (cnt_dec),
      .last (cnt_last)
   );

   // State register. Reset drops any access in flight, which also pulls
   // mem_cs low immediately since mem_cs is decoded from the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode. req_ready depends on the state alone
   // so there is no combinational path from req_valid back to req_ready.
   // DONE can accept a new request and go straight to ISSUE, which gives
   // one access every LATENCY+1 cycles under a continuous request stream.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      busy       = 1'b1;
      mem_cs     = 1'b0;
      resp_valid = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      accept     = 1'b0;
      wait_done  = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            mem_cs     = 1'b1;
            cnt_load   = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            cnt_dec = 1'b1;
            if (cnt_last) begin
               wait_done  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            req_ready  = 1'b1;
            resp_valid = 1'b1;
            if (req_valid) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Memory bus and response data. The bus is loaded only on accept, so it
   // stays frozen from ISSUE through the last WAIT cycle whatever req_*
   // does meanwhile. On the final wait edge, wen returns to the read level
   // and read data is captured; writes leave resp_rdata alone. Address and
   // write data simply keep their last values between accesses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_wen     <= WEN_READ;
         mem_addr    <= '0;
         mem_data_in <= '0;
         resp_rdata  <= '0;
      end else if (accept) begin
         mem_wen     <= req_wen;
         mem_addr    <= req_addr;
         mem_data_in <= req_wdata;
      end else if (wait_done) begin
         mem_wen <= WEN_READ;
         if (mem_wen == WEN_READ) begin
            resp_rdata <= mem_data_out;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl with LATENCY=3 against a behavioural
// 3-cycle memory. Expected response data is pushed to a scoreboard queue
// when a request is presented and popped when resp_valid is seen.

module tb_mem_access_ctrl;
   import mem_ctrl_pkg::*;

   localparam int ASIZE = 16;
   localparam int DSIZE = 16;
   localparam int LAT   = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_wen = WEN_READ;
   logic [ASIZE-1:0] req_addr = '0;
   logic [DSIZE-1:0] req_wdata = '0;
   logic             resp_valid;
   logic [DSIZE-1:0] resp_rdata;
   logic             busy;
   logic             mem_cs;
   logic             mem_wen;
   logic [ASIZE-1:0] mem_addr;
   logic [DSIZE-1:0] mem_data_in;
   logic [DSIZE-1:0] mem_data_out = '0;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [DSIZE-1:0] exp_q[$];
   logic [DSIZE-1:0] shadow[int];
   logic [DSIZE-1:0] rdata_track = '0;

   mem_access_ctrl #(
      .ASIZE   (ASIZE),
      .DSIZE   (DSIZE),
      .LATENCY (LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wen      (req_wen),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .busy         (busy),
      .mem_cs       (mem_cs),
      .mem_wen      (mem_wen),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   // 10 ns clock and a free-running cycle counter for spacing checks.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural memory: samples cs and the address, presents read data
   // one edge before the end of the access, and commits a write on the
   // final edge only if wen is still low there.
   logic [DSIZE-1:0] mem_array [0:65535];
   logic [ASIZE-1:0] m_addr = '0;
   int               m_cnt  = 0;

   always @(posedge clk) begin
      if (mem_cs) begin
         m_addr <= mem_addr;
         m_cnt  <= LAT - 1;
      end else if (m_cnt == 2) begin
         m_cnt <= 1;
         if (mem_wen == WEN_READ) mem_data_out <= mem_array[m_addr];
      end else if (m_cnt == 1) begin
         m_cnt <= 0;
         if (mem_wen == WEN_WRITE) mem_array[m_addr] <= mem_data_in;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Response monitor: pops the scoreboard on every resp_valid and watches
   // for back-to-back chip selects.
   logic prev_cs = 1'b0;
   always @(negedge clk) begin
      if (mem_cs) check_output("cs_not_consecutive", 32'(prev_cs), 32'd0);
      prev_cs = mem_cs;
      if (resp_valid) begin
         check_output("resp_expected", 32'(exp_q.size() == 0), 32'd0);
         if (exp_q.size() != 0) check_output("resp_rdata", 32'(resp_rdata), 32'(exp_q.pop_front()));
      end
   end

   // Presents one request from a negedge, waits (bounded) for req_ready,
   // records the expected response and returns at the negedge of ISSUE.
   task automatic apply_stimulus(input logic wen, input logic [ASIZE-1:0] addr,
                                 input logic [DSIZE-1:0] data, input bit hold,
                                 output int acc_cyc);
      int n = 0;
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = data;
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_output("accept_in_time", 32'(req_ready), 32'd1);
      if (wen == WEN_READ) rdata_track = shadow[int'(addr)];
      else shadow[int'(addr)] = data;
      exp_q.push_back(rdata_track);
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      if (!hold) req_valid = 1'b0;
   endtask

   // Bounded wait for the controller to go idle with no response pending.
   task automatic drain();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_output("drain_in_time", 32'(busy || exp_q.size() != 0), 32'd0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence: reset, single read, single write, back-to-back
   // writes with readback, request churn, reset during a write.
   initial begin
      int acc;
      int prev_acc;
      int cs_count;

      // Reset held for two cycles.
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check_output("rst_mem_cs",      32'(mem_cs),      32'd0);
      check_output("rst_mem_wen",     32'(mem_wen),     32'd1);
      check_output("rst_mem_addr",    32'(mem_addr),    32'd0);
      check_output("rst_mem_data_in", 32'(mem_data_in), 32'd0);
      check_output("rst_resp_valid",  32'(resp_valid),  32'd0);
      check_output("rst_resp_rdata",  32'(resp_rdata),  32'd0);
      check_output("rst_busy",        32'(busy),        32'd0);
      check_output("rst_req_ready",   32'(req_ready),   32'd1);
      rst = 1'b1;
      @(negedge clk);

      // Single read of 0x0005 after loading 0x1234 there.
      apply_stimulus(WEN_WRITE, 16'h0005, 16'h1234, 1'b0, acc);
      drain();
      apply_stimulus(WEN_READ, 16'h0005, 16'h0000, 1'b0, acc);
      check_output("rd_c1_cs",    32'(mem_cs),    32'd1);
      check_output("rd_c1_ready", 32'(req_ready), 32'd0);
      check_output("rd_c1_busy",  32'(busy),      32'd1);
      check_output("rd_c1_wen",   32'(mem_wen),   32'd1);
      check_output("rd_c1_addr",  32'(mem_addr),  32'h0005);
      for (int k = 2; k <= 3; k++) begin
         @(negedge clk);
         check_output("rd_wait_cs",   32'(mem_cs),     32'd0);
         check_output("rd_wait_addr", 32'(mem_addr),   32'h0005);
         check_output("rd_wait_resp", 32'(resp_valid), 32'd0);
      end
      @(negedge clk);
      check_output("rd_c4_resp_valid", 32'(resp_valid), 32'd1);
      check_output("rd_c4_resp_rdata", 32'(resp_rdata), 32'h1234);
      drain();

      // Single write of 0xFFFF to 0x0000, then readback.
      apply_stimulus(WEN_WRITE, 16'h0000, 16'hFFFF, 1'b0, acc);
      for (int k = 1; k <= 3; k++) begin
         check_output("wr_hold_wen",  32'(mem_wen),     32'd0);
         check_output("wr_hold_data", 32'(mem_data_in), 32'hFFFF);
         @(negedge clk);
      end
      check_output("wr_c4_resp_valid", 32'(resp_valid), 32'd1);
      check_output("wr_c4_rdata_kept", 32'(resp_rdata), 32'h1234);
      check_output("wr_c4_wen_back",   32'(mem_wen),    32'd1);
      drain();
      apply_stimulus(WEN_READ, 16'h0000, 16'h0000, 1'b0, acc);
      drain();

      // Back-to-back writes with req_valid held, then back-to-back reads.
      prev_acc = 0;
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(WEN_WRITE, 16'(i), 16'hFFFF - 16'(i), 1'b1, acc);
         if (i > 0) check_output("b2b_wr_spacing", 32'(acc - prev_acc), 32'd4);
         prev_acc = acc;
      end
      req_valid = 1'b0;
      drain();
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(WEN_READ, 16'(i), 16'h0000, 1'b1, acc);
         if (i > 0) check_output("b2b_rd_spacing", 32'(acc - prev_acc), 32'd4);
         prev_acc = acc;
      end
      req_valid = 1'b0;
      drain();

      // Request churn while an access is in flight.
      apply_stimulus(WEN_READ, 16'h0005, 16'h0000, 1'b0, acc);
      cs_count = 0;
      for (int k = 0; k < 3; k++) begin
         if (k < 2) begin
            req_valid = 1'b1;
            req_wen   = ~req_wen;
            req_addr  = 16'h1000 + 16'(k);
         end else begin
            req_valid = 1'b0;
         end
         check_output("churn_addr",  32'(mem_addr),  32'h0005);
         check_output("churn_wen",   32'(mem_wen),   32'd1);
         check_output("churn_ready", 32'(req_ready), 32'd0);
         cs_count += int'(mem_cs);
         @(negedge clk);
      end
      check_output("churn_resp_valid", 32'(resp_valid), 32'd1);
      check_output("churn_cs_done",    32'(mem_cs),     32'd0);
      check_output("churn_cs_count",   32'(cs_count),   32'd1);
      drain();

      // Reset during the wait phase of a write to 0x0010.
      apply_stimulus(WEN_WRITE, 16'h0010, 16'hAAAA, 1'b0, acc);
      drain();
      apply_stimulus(WEN_WRITE, 16'h0010, 16'h5555, 1'b0, acc);
      @(negedge clk);
      check_output("abort_pre_wen", 32'(mem_wen), 32'd0);
      #2 rst = 1'b0;
      #1;
      check_output("abort_wen",        32'(mem_wen),    32'd1);
      check_output("abort_cs",         32'(mem_cs),     32'd0);
      check_output("abort_resp_valid", 32'(resp_valid), 32'd0);
      check_output("abort_busy",       32'(busy),       32'd0);
      exp_q.delete();
      shadow[16'h0010] = 16'hAAAA;
      rdata_track = '0;
      repeat (2) @(negedge clk);
      check_output("abort_rdata_reset", 32'(resp_rdata), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      apply_stimulus(WEN_READ, 16'h0010, 16'h0000, 1'b0, acc);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

CPU-side initiator for the fixed-latency data memory (`memory`): accepts one load/store request at a time from the pipeline and drives the memory's `cs`/`wen`/`addr`/`data_in` pins at the rate the memory requires. It holds the memory bus stable for the full access latency, captures `data_out`, and returns a one-cycle response. It sits between the Phase 2 datapath and `memory`, replacing the hand-timed stimulus used in bench-level memory tests.

## Interface
- `ASIZE`, 16, address width
- `DSIZE`, 16, data width
- `LATENCY`, 3, memory access latency in cycles, counted from the `cs` cycle; legal range ≥2
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted on an edge where `req_valid` and `req_ready` are both 1
- `req_wen` in 1: 0 = write, 1 = read (memory polarity)
- `req_addr` in ASIZE: access address
- `req_wdata` in DSIZE: write data
- `resp_valid` out 1: one-cycle completion pulse, for reads and writes
- `resp_rdata` out DSIZE: read data, valid with `resp_valid` on reads
- `busy` out 1: state ≠ IDLE
- `mem_cs` out 1: memory chip select, active high
- `mem_wen` out 1: memory write enable, active low
- `mem_addr` out ASIZE: memory address
- `mem_data_in` out DSIZE: memory write data
- `mem_data_out` in DSIZE: memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** `req_ready`=1. On accept:
  - latch `req_wen`/`req_addr`/`req_wdata` onto `mem_wen`/`mem_addr`/`mem_data_in`;
  - go to ISSUE.
- **ISSUE:** `mem_cs`=1 for exactly this cycle. Load the latency counter with LATENCY-1, then go to WAIT.
- **WAIT:** `mem_cs`=0. Decrement the counter each cycle.
  - At the edge where the counter is 1, go to DONE.
  - On reads, also capture `mem_data_out` into `resp_rdata` at that edge.
- **DONE:**
  - `resp_valid`=1 and `mem_wen` returns to 1.
  - `req_ready`=1. An accept here goes directly to ISSUE (back-to-back); otherwise go to IDLE.
- Bus hold: `mem_addr`, `mem_data_in` and `mem_wen` are constant from ISSUE through the last WAIT cycle (LATENCY cycles in total). `req_*` changes in this window have no effect.
- Idle bus: `mem_addr`/`mem_data_in` keep their last values; `mem_wen`=1; `mem_cs`=0.
- Writes leave `resp_rdata` unchanged.
- Counter width is $clog2(LATENCY+1). The counter never wraps: it is loaded only in ISSUE.

## Timing
- Reset values (applied asynchronously while `rst`=0):
  - state IDLE;
  - `mem_cs`=0, `mem_wen`=1;
  - `mem_addr`=0, `mem_data_in`=0;
  - `resp_valid`=0, `resp_rdata`=0;
  - `busy`=0, `req_ready`=1.
- Latency: accept at edge E0 → ISSUE in cycle 1 → WAIT in cycles 2..LATENCY → `resp_valid` in cycle LATENCY+1.
- Throughput: one access per LATENCY+1 cycles when `req_valid` is held high.
- `req_ready` is combinational from state only: 1 in IDLE/DONE, 0 in ISSUE/WAIT. It has no combinational path from `req_valid`.
- Reset asserted mid-access (ISSUE/WAIT/DONE):
  - `mem_cs`→0 and `mem_wen`→1 immediately, with no clock edge needed;
  - the access is dropped and no `resp_valid` is produced;
  - a pending request must be re-presented after reset.
- `mem_cs` is never high in two consecutive cycles.

## Structure
- Shared package `mem_ctrl_pkg`:
  - state enum (IDLE/ISSUE/WAIT/DONE);
  - `WEN_WRITE`=0 and `WEN_READ`=1 constants;
  - default `MEM_LATENCY`=3.
- One sub-module: `lat_counter`, a loadable down-counter with a `last` flag (count==1), parameterised on LATENCY. The FSM and bus registers stay in `mem_access_ctrl`.

## Test plan
All scenarios use LATENCY=3, a 10 ns clock, and a behavioural 3-cycle `memory` model.
1. Reset: hold `rst`=0 for 2 cycles → all outputs at their reset values, `req_ready`=1, `busy`=0.
2. Single read:
   - stimulus: memory preloaded with [0x0005]=0x1234; read 0x0005;
   - `mem_cs` is high for 1 cycle and `mem_addr`=0x0005 is stable for 3 cycles;
   - `resp_valid` pulses in cycle 4 after accept with `resp_rdata`=0x1234.
3. Single write of 0xFFFF to 0x0000:
   - `mem_wen`=0 and `mem_data_in`=0xFFFF for 3 cycles;
   - `resp_valid` pulses and `resp_rdata` is unchanged;
   - a readback of 0x0000 returns 0xFFFF.
4. Back-to-back: `req_valid` held high for 20 writes, addresses 0x0000..0x0013, data 0xFFFF decrementing:
   - one accept every 4 cycles and all writes land;
   - 20 readbacks return 0xFFFF..0xFFEC.
5. Request churn: `req_addr` toggles every cycle during WAIT → `mem_addr` is unchanged, `req_ready`=0 in ISSUE/WAIT, and no extra `mem_cs` pulse occurs.
6. Reset during WAIT of a write to 0x0010 (old value 0xAAAA):
   - `mem_wen`→1 and `mem_cs`→0 immediately, with no `resp_valid`;
   - after reset, a read of 0x0010 returns 0xAAAA (the write was aborted before the memory's write point).
